// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer.
//
// This block drives the PC into the instruction ROM. It reads back the
// decoded opcode and uses it to pick the next PC: increment, jump,
// conditional branch, halt, or the illegal TBA opcode. The datapath
// supplies the jump/branch target and the branch condition.
//
// State table:
//   state | meaning
//   IDLE  | after reset; waits for start, ignores opcode
//   RUN   | retires one instruction per unstalled cycle
//   HALT  | stopped by HALT/TBA; waits for start to restart
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset (highest priority)
//   start        in   begin execution at start_addr (IDLE/HALT only)
//   start_addr   in   first PC to execute
//   opcode       in   opcode at current pc (combinational from ROM)
//   branch_cond  in   1 = take the current conditional branch
//   target       in   jump/branch destination
//   stall        in   freezes RUN for the cycle
//   pc           out  current program counter (registered)
//   running      out  high in RUN
//   halted       out  high in HALT
//   illegal      out  sticky, set when TBA is executed
//   retire       out  one-cycle pulse per completed instruction
//   instr_count  out  retired-instruction count, saturating
module pc_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_addr,
    input  logic [3:0]        opcode,
    input  logic              branch_cond,
    input  logic [PC_W-1:0]   target,
    input  logic              stall,
    output logic [PC_W-1:0]   pc,
    output logic              running,
    output logic              halted,
    output logic              illegal,
    output logic              retire,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_TBA  = 4'b1111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              illegal_q, illegal_d;
    logic              retire_q, retire_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PC_W-1:0]   pc_inc;
    logic [CNT_W-1:0]  cnt_inc;

    // The PC wraps modulo 2^PC_W, and the counter sticks at all-ones.
    assign pc_inc  = pc_q + 1'b1;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            illegal_q <= 1'b0;
            retire_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
            retire_q  <= retire_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        retire_d  = 1'b0;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                // stall has no effect outside RUN
                if (start) begin
                    state_d   = ST_RUN;
                    pc_d      = start_addr;
                    cnt_d     = '0;
                    illegal_d = 1'b0;
                end
            end

            ST_RUN: begin
                // start is ignored here: there is no restart while running
                if (!stall) begin
                    retire_d = 1'b1;
                    cnt_d    = cnt_inc;
                    unique case (opcode)
                        OP_JMP: pc_d = target;
                        OP_BNE, OP_BEQ, OP_BLT:
                            pc_d = branch_cond ? target : pc_inc;
                        OP_HALT: state_d = ST_HALT;
                        OP_TBA: begin
                            state_d   = ST_HALT;
                            illegal_d = 1'b1;
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign pc          = pc_q;
    assign running     = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT);
    assign illegal     = illegal_q;
    assign retire      = retire_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with the default 16-bit widths
    logic        reset, start, branch_cond, stall;
    logic [15:0] start_addr, target;
    logic [3:0]  opcode;
    logic [15:0] pc;
    logic        running, halted, illegal, retire;
    logic [15:0] instr_count;

    pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .opcode(opcode), .branch_cond(branch_cond), .target(target),
        .stall(stall), .pc(pc), .running(running), .halted(halted),
        .illegal(illegal), .retire(retire), .instr_count(instr_count)
    );

    // Instance with a 4-bit counter, used to check saturation
    logic        reset4, start4;
    logic [15:0] pc4;
    logic        running4, halted4, illegal4, retire4;
    logic [3:0]  instr_count4;

    pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset4), .start(start4), .start_addr(16'h0000),
        .opcode(4'b0100), .branch_cond(1'b0), .target(16'h0000),
        .stall(1'b0), .pc(pc4), .running(running4), .halted(halted4),
        .illegal(illegal4), .retire(retire4), .instr_count(instr_count4)
    );

    typedef struct {
        logic        rst;
        logic        st;
        logic        stl;
        logic        cond;
        logic [3:0]  op;
        logic [15:0] addr;
        logic [15:0] tgt;
        logic [15:0] e_pc;
        logic        e_run;
        logic        e_halt;
        logic        e_ill;
        logic        e_ret;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic st, input logic stl,
                       input logic cond, input logic [3:0] op,
                       input logic [15:0] addr, input logic [15:0] tgt,
                       input logic [15:0] e_pc, input logic e_run,
                       input logic e_halt, input logic e_ill,
                       input logic e_ret, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.cond = cond; v.op = op;
        v.addr = addr; v.tgt = tgt; v.e_pc = e_pc; v.e_run = e_run;
        v.e_halt = e_halt; v.e_ill = e_ill; v.e_ret = e_ret; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_cond = 1'b0;
        opcode = 4'h0; start_addr = 16'h0; target = 16'h0;
        reset4 = 1'b1; start4 = 1'b0;

        //   rst st stl cnd op    addr     tgt      pc       run hlt ill ret cnt
        // reset, then a linear run 0..5 ending in HALT
        add(1, 0, 0, 0, 4'h0, 16'h0,    16'h0,    16'h0000, 0, 0, 0, 0, 16'd0);
        add(0, 1, 0, 0, 4'h0, 16'h0,    16'h0,    16'h0000, 1, 0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 4'h4, 16'h0,    16'h0,    16'h0001, 1, 0, 0, 1, 16'd1);
        add(0, 0, 0, 0, 4'hD, 16'h0,    16'h0,    16'h0002, 1, 0, 0, 1, 16'd2);
        add(0, 0, 0, 0, 4'h4, 16'h0,    16'h0,    16'h0003, 1, 0, 0, 1, 16'd3);
        add(0, 0, 0, 0, 4'h9, 16'h0,    16'h0,    16'h0004, 1, 0, 0, 1, 16'd4);
        add(0, 0, 0, 0, 4'h6, 16'h0,    16'h0,    16'h0005, 1, 0, 0, 1, 16'd5);
        add(0, 0, 0, 0, 4'hE, 16'h0,    16'h0,    16'h0005, 0, 1, 0, 1, 16'd6);
        add(0, 0, 0, 0, 4'h0, 16'h0,    16'h0,    16'h0005, 0, 1, 0, 0, 16'd6);
        // restart at 3; taken BEQ, JMP, not-taken BEQ, taken BNE
        add(0, 1, 0, 0, 4'h0, 16'h3,    16'h0,    16'h0003, 1, 0, 0, 0, 16'd0);
        add(0, 0, 0, 1, 4'hB, 16'h0,    16'd10,   16'd10,   1, 0, 0, 1, 16'd1);
        add(0, 0, 0, 0, 4'h2, 16'h0,    16'h0100, 16'h0100, 1, 0, 0, 1, 16'd2);
        add(0, 0, 0, 0, 4'hB, 16'h0,    16'h0055, 16'h0101, 1, 0, 0, 1, 16'd3);
        add(0, 0, 0, 1, 4'hA, 16'h0,    16'h0007, 16'h0007, 1, 0, 0, 1, 16'd4);
        // stall three cycles at pc 7, then resume
        add(0, 0, 1, 0, 4'h4, 16'h0,    16'h0,    16'h0007, 1, 0, 0, 0, 16'd4);
        add(0, 0, 1, 0, 4'h4, 16'h0,    16'h0,    16'h0007, 1, 0, 0, 0, 16'd4);
        add(0, 0, 1, 0, 4'h4, 16'h0,    16'h0,    16'h0007, 1, 0, 0, 0, 16'd4);
        add(0, 0, 0, 0, 4'h4, 16'h0,    16'h0,    16'h0008, 1, 0, 0, 1, 16'd5);
        // BLT taken to 2, then TBA there
        add(0, 0, 0, 1, 4'hC, 16'h0,    16'h0002, 16'h0002, 1, 0, 0, 1, 16'd6);
        add(0, 0, 0, 0, 4'hF, 16'h0,    16'h0,    16'h0002, 0, 1, 1, 1, 16'd7);
        add(0, 0, 1, 0, 4'h4, 16'h0,    16'h0,    16'h0002, 0, 1, 1, 0, 16'd7);
        // restart clears illegal; start is ignored while running
        add(0, 1, 0, 0, 4'h0, 16'h0020, 16'h0,    16'h0020, 1, 0, 0, 0, 16'd0);
        add(0, 1, 0, 0, 4'h4, 16'h0099, 16'h0,    16'h0021, 1, 0, 0, 1, 16'd1);
        // reset mid-run, then reset together with start
        add(1, 0, 0, 0, 4'h2, 16'h0,    16'h0,    16'h0000, 0, 0, 0, 0, 16'd0);
        add(1, 1, 0, 0, 4'h0, 16'h0044, 16'h0,    16'h0000, 0, 0, 0, 0, 16'd0);
        // PC wrap from all-ones
        add(0, 1, 0, 0, 4'h0, 16'hFFFF, 16'h0,    16'hFFFF, 1, 0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 4'h5, 16'h0,    16'h0,    16'h0000, 1, 0, 0, 1, 16'd1);
        add(1, 0, 0, 0, 4'h4, 16'h0,    16'h0,    16'h0000, 0, 0, 0, 0, 16'd0);
        // IDLE ignores opcode when start is low
        add(0, 0, 0, 0, 4'hE, 16'h0,    16'h0,    16'h0000, 0, 0, 0, 0, 16'd0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            reset = vecs[i].rst; start = vecs[i].st; stall = vecs[i].stl;
            branch_cond = vecs[i].cond; opcode = vecs[i].op;
            start_addr = vecs[i].addr; target = vecs[i].tgt;
            @(posedge clk); #1;
            chk("pc",      i, 32'(pc),          32'(vecs[i].e_pc));
            chk("running", i, 32'(running),     32'(vecs[i].e_run));
            chk("halted",  i, 32'(halted),      32'(vecs[i].e_halt));
            chk("illegal", i, 32'(illegal),     32'(vecs[i].e_ill));
            chk("retire",  i, 32'(retire),      32'(vecs[i].e_ret));
            chk("count",   i, 32'(instr_count), 32'(vecs[i].e_cnt));
        end

        // ROM-driven run: ALU ops at pc 0..2, HALT at pc 3, bounded wait
        reset = 1'b0; stall = 1'b0; start_addr = 16'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int budget = 20;
            while (!halted && budget > 0) begin
                opcode = (pc == 16'h3) ? 4'hE : 4'h1;
                @(posedge clk); #1;
                budget--;
            end
            chk("rom_halt_seen", 100, 32'(halted), 32'd1);
            chk("rom_halt_pc",   100, 32'(pc), 32'h3);
            chk("rom_halt_cnt",  100, 32'(instr_count), 32'd4);
        end

        // Saturation on the 4-bit counter: 20 ALU instructions
        reset4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("sat_start_cnt", 200, 32'(instr_count4), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk("sat_cnt", 200 + k, 32'(instr_count4), (k > 15) ? 32'd15 : 32'(k));
        end
        chk("sat_pc",     300, 32'(pc4), 32'd20);
        chk("sat_retire", 300, 32'(retire4), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
